// File: rtl/instr_enc_loader_if.sv
// Stream/memory bundle for the instruction encoder-loader.
// The loader takes the slave view; the program source / memory model takes the master view.
interface instr_enc_loader_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 9
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_f3;
    logic [6:0]        in_f7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic              done;
    logic              full;
    logic              err_flag;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  word_cnt;

    modport slave (
        input  start, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2, in_f3, in_f7,
               in_imm, in_last, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata, done, full, err_flag, err_cnt, word_cnt
    );

    modport master (
        output start, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2, in_f3, in_f7,
               in_imm, in_last, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, full, err_flag, err_cnt, word_cnt
    );
endinterface

// File: rtl/instr_enc_loader.sv
// Assembles RV32I instruction fields into 32-bit words and writes them to sequential
// instruction-memory addresses; illegal entries are dropped and counted.
module instr_enc_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_enc_loader_if.slave   bus
);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_U = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              last_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic              err_flag_q;
    logic              full_q;

    logic [31:0] imm;
    logic        op_known;
    logic [2:0]  op_fmt;
    logic        range_ok;
    logic        enc_legal;
    logic [31:0] enc_word;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        slot_last;

    assign imm = bus.in_imm;

    // An immediate fits N signed bits when every bit from N-1 upward equals the sign.
    assign fits12 = (&imm[31:11]) | (~|imm[31:11]);
    assign fits13 = (&imm[31:12]) | (~|imm[31:12]);
    assign fits21 = (&imm[31:20]) | (~|imm[31:20]);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_known = 1'b1;
        op_fmt   = FMT_I;
        case (bus.in_op)
            OP_REG:                     op_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:   op_fmt = FMT_I;
            OP_STORE:                   op_fmt = FMT_S;
            OP_BRANCH:                  op_fmt = FMT_B;
            OP_JAL:                     op_fmt = FMT_J;
            OP_AUIPC, OP_LUI:           op_fmt = FMT_U;
            default:                    op_known = 1'b0;
        endcase
    end

    always_comb begin
        range_ok = 1'b0;
        enc_word = '0;
        case (bus.in_fmt)
            FMT_R: begin
                range_ok = 1'b1;
                enc_word = {bus.in_f7, bus.in_rs2, bus.in_rs1, bus.in_f3, bus.in_rd, bus.in_op};
            end
            FMT_I: begin
                range_ok = fits12;
                enc_word = {imm[11:0], bus.in_rs1, bus.in_f3, bus.in_rd, bus.in_op};
            end
            FMT_S: begin
                range_ok = fits12;
                enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_f3, imm[4:0], bus.in_op};
            end
            FMT_B: begin
                range_ok = fits13 && !imm[0];
                enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_f3,
                            imm[4:1], imm[11], bus.in_op};
            end
            FMT_U: begin
                range_ok = (imm[11:0] == 12'd0);
                enc_word = {imm[31:12], bus.in_rd, bus.in_op};
            end
            FMT_J: begin
                range_ok = fits21 && !imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_op};
            end
            default: begin
                range_ok = 1'b0;
                enc_word = '0;
            end
        endcase
    end

    // Formats 110/111 never equal a decoded op_fmt, so they fall out as illegal here.
    assign enc_legal = op_known && (op_fmt == bus.in_fmt) && range_ok;
    assign slot_last = (word_cnt_q == LAST_SLOT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state      <= S_RUN;
                        addr_q     <= BASE_ADDR;
                        word_cnt_q <= '0;
                        err_cnt_q  <= '0;
                        err_flag_q <= 1'b0;
                        full_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.in_valid) begin
                        if (enc_legal) begin
                            wdata_q <= enc_word;
                            last_q  <= bus.in_last;
                            state   <= S_WRITE;
                        end else begin
                            if (err_cnt_q != CNT_MAX) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                            err_flag_q <= 1'b1;
                            state      <= bus.in_last ? S_DONE : S_RUN;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        addr_q     <= addr_q + ADDR_W'(4);
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (slot_last) begin
                            full_q <= 1'b1;
                        end
                        state <= (last_q || slot_last) ? S_DONE : S_RUN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_RUN);
    assign bus.mem_we    = (state == S_WRITE);
    assign bus.done      = (state == S_DONE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.full      = full_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_instr_enc_loader.sv
// Scoreboard bench for instr_enc_loader: a field-level reference model predicts writes and
// session status, and an independent monitor compares them against the memory port and done pulse.
module tb_instr_enc_loader;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam int          CNT_W  = $clog2(DEPTH + 1);
    localparam logic [31:0] BASE   = 32'hFFFF_FFF8;
    localparam int          ERRMAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          last;
    } ent_t;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int words; int errs; bit eflag; bit full; } sess_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_enc_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    instr_enc_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wr_t   exp_wr[$];
    sess_t exp_sess[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    stall_cnt = 0;
    bit    aborted = 0;

    logic [31:0] m_addr;
    int          m_words, m_errs;
    bit          m_eflag, m_full, m_active;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Legality from the ISA rules: opcode implies one format, immediates must fit their field.
    function automatic bit ref_legal(input ent_t e);
        int     want;
        longint s;
        s = longint'($signed(e.imm));
        case (e.op)
            7'b0110011:                         want = 5;
            7'b0010011, 7'b0000011, 7'b1100111: want = 0;
            7'b0100011:                         want = 1;
            7'b1100011:                         want = 2;
            7'b1101111:                         want = 3;
            7'b0010111, 7'b0110111:             want = 4;
            default:                            return 1'b0;
        endcase
        if (int'(e.fmt) != want) return 1'b0;
        case (e.fmt)
            3'd0, 3'd1: return (s >= -2048) && (s <= 2047);
            3'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            3'd3:       return (s >= -(64'sd1 << 20)) && (s < (64'sd1 << 20)) && (s % 2 == 0);
            3'd4:       return (e.imm % 4096) == 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input ent_t e);
        logic [31:0] op, rd, f3, rs1, rs2, f7, imm;
        op  = 32'(e.op);  rd  = 32'(e.rd) << 7;   f3 = 32'(e.f3) << 12;
        rs1 = 32'(e.rs1) << 15; rs2 = 32'(e.rs2) << 20; f7 = 32'(e.f7) << 25;
        imm = e.imm;
        case (e.fmt)
            3'd5: return op | rd | f3 | rs1 | rs2 | f7;
            3'd0: return op | rd | f3 | rs1 | ((imm & 32'hFFF) << 20);
            3'd1: return op | ((imm & 32'h1F) << 7) | f3 | rs1 | rs2 | (((imm >> 5) & 32'h7F) << 25);
            3'd2: return op | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 32'hF) << 8) | f3 | rs1 | rs2
                         | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 1) << 31);
            3'd4: return op | rd | (imm & 32'hFFFF_F000);
            default: return op | rd | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 1) << 20)
                            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 1) << 31);
        endcase
    endfunction

    function automatic ent_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [31:0] imm, input bit last);
        ent_t e;
        e.fmt = fmt; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = 7'h20; e.imm = imm; e.last = last;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t        e;
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        int          bnd[10];
        bnd = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, (1 << 20) - 2, 1 << 20, -(1 << 20)};
        e.fmt = ($urandom % 10 == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
        case (e.fmt)
            3'd0: case ($urandom % 3)
                      0:       e.op = 7'b0010011;
                      1:       e.op = 7'b0000011;
                      default: e.op = 7'b1100111;
                  endcase
            3'd1: e.op = 7'b0100011;
            3'd2: e.op = 7'b1100011;
            3'd3: e.op = 7'b1101111;
            3'd4: e.op = ($urandom % 2 == 0) ? 7'b0010111 : 7'b0110111;
            3'd5: e.op = 7'b0110011;
            default: e.op = 7'($urandom);
        endcase
        if ($urandom % 6 == 0) e.op = 7'($urandom);
        e.rd = 5'($urandom); e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
        e.f3 = 3'($urandom); e.f7 = 7'($urandom);
        t12 = 12'($urandom); t13 = 13'($urandom); t21 = 21'($urandom);
        case ($urandom % 6)
            0:       e.imm = $urandom;
            1:       e.imm = {{20{t12[11]}}, t12};
            2:       e.imm = {{19{t13[12]}}, t13};
            3:       e.imm = {{11{t21[20]}}, t21};
            4:       e.imm = $urandom & 32'hFFFF_F000;
            default: e.imm = 32'(bnd[$urandom % 10]);
        endcase
        if ((e.fmt == 3'd2 || e.fmt == 3'd3) && ($urandom % 4 != 0)) e.imm[0] = 1'b0;
        e.last = 1'b0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ent_t e);
        bus.in_fmt = e.fmt; bus.in_op = e.op; bus.in_rd = e.rd; bus.in_rs1 = e.rs1;
        bus.in_rs2 = e.rs2; bus.in_f3 = e.f3; bus.in_f7 = e.f7; bus.in_imm = e.imm;
        bus.in_last = e.last; bus.in_valid = 1'b1;
    endtask

    task automatic end_session();
        exp_sess.push_back('{m_words, m_errs, m_eflag, m_full});
        m_active = 1'b0;
    endtask

    task automatic model_accept(input ent_t e);
        if (ref_legal(e)) begin
            exp_wr.push_back('{m_addr, ref_encode(e)});
            m_addr += 32'd4;
            m_words++;
            if (m_words == DEPTH) begin
                m_full = 1'b1;
                end_session();
                return;
            end
        end else begin
            if (m_errs < ERRMAX) m_errs++;
            m_eflag = 1'b1;
        end
        if (e.last) end_session();
    endtask

    task automatic recover();
        rst_n = 1'b0;
        exp_wr.delete();
        exp_sess.delete();
        m_active = 1'b0;
        aborted = 1'b1;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        stall_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic start_session();
        aborted = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        m_addr = BASE; m_words = 0; m_errs = 0; m_eflag = 1'b0; m_full = 1'b0; m_active = 1'b1;
    endtask

    task automatic send(input ent_t e);
        bit ok = 1'b0;
        repeat ($urandom % 3) tick();
        drive(e);
        bus.start = ($urandom % 4 == 0);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            recover();
            return;
        end
        model_accept(e);
    endtask

    task automatic wait_done(output bit saw_ready);
        bit got = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (bus.in_ready) saw_ready = 1'b1;
            if (bus.done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 32'(bus.done), 32'd1);
            recover();
            return;
        end
        @(negedge clk);
        if (bus.in_ready) saw_ready = 1'b1;
        tick();
    endtask

    // Entries left over after a full-ended session stay presented to prove they are refused.
    task automatic run_session(input ent_t ents[$]);
        bit saw;
        int i = 0;
        start_session();
        while (i < ents.size() && m_active && !aborted) begin
            send(ents[i]);
            i++;
        end
        if (aborted) return;
        if (i < ents.size()) drive(ents[i]);
        wait_done(saw);
        bus.in_valid = 1'b0;
        if (!aborted) check("ready_after_session_end", 32'(saw), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_we"},   32'(bus.mem_we),   32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr,      BASE);
        check({tag, "_mem_wdata"}, bus.mem_wdata,    32'd0);
        check({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd0);
        check({tag, "_err_cnt"},  32'(bus.err_cnt),  32'd0);
        check({tag, "_err_flag"}, 32'(bus.err_flag), 32'd0);
        check({tag, "_full"},     32'(bus.full),     32'd0);
    endtask

    // Monitor: every cycle with mem_we up must present the head expected write; ack retires it.
    always @(negedge clk) begin : monitor
        sess_t s;
        if (rst_n) begin
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(bus.mem_we), 32'd0);
                end else begin
                    check("wr_addr", bus.mem_addr, exp_wr[0].addr);
                    check("wr_data", bus.mem_wdata, exp_wr[0].data);
                    if (bus.mem_ack) void'(exp_wr.pop_front());
                end
            end
            if (bus.done) begin
                if (exp_sess.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    s = exp_sess.pop_front();
                    check("done_word_cnt", 32'(bus.word_cnt), 32'(s.words));
                    check("done_err_cnt",  32'(bus.err_cnt),  32'(s.errs));
                    check("done_err_flag", 32'(bus.err_flag), 32'(s.eflag));
                    check("done_full",     32'(bus.full),     32'(s.full));
                    check("writes_pending_at_done", 32'(exp_wr.size()), 32'd0);
                end
            end
        end
    end

    initial begin : ack_driver
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.mem_ack = 1'b0;
                if (bus.mem_we) stall_cnt--;
            end else begin
                bus.mem_ack = ($urandom % 3 != 0);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        ent_t q[$];
        bit   saw;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_op = '0; bus.in_rd = '0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_f3 = '0; bus.in_f7 = '0; bus.in_imm = '0;
        bus.in_last = 1'b0;
        m_active = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        q = '{mk(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1)};
        run_session(q);

        q = '{mk(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8, 1'b0),
              mk(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 1'b1)};
        run_session(q);

        stall_cnt = 3;
        q = '{mk(3'd3, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 1'b1)};
        run_session(q);

        q = '{mk(3'd2, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0),
              mk(3'd1, 7'b0010011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4, 1'b0),
              mk(3'd0, 7'b0010011, 5'd3, 5'd1, 5'd0, 3'd0, 32'h800, 1'b1)};
        run_session(q);

        q.delete();
        for (int i = 0; i < 5; i++)
            q.push_back(mk(3'd0, 7'b0010011, 5'(i + 1), 5'd2, 5'd0, 3'd0, 32'(i * 3), i == 4));
        run_session(q);

        q.delete();
        for (int i = 0; i < 9; i++)
            q.push_back(mk(3'd4, 7'b0110111, 5'd4, 5'd0, 5'd0, 3'd0, 32'h0000_1001, i == 8));
        run_session(q);

        start_session();
        stall_cnt = 1000;
        send(mk(3'd5, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd3, 32'd0, 1'b1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_wr.delete();
        exp_sess.delete();
        m_active = 1'b0;
        #1 check_idle("rst_mid_write");
        repeat (2) @(posedge clk);
        @(negedge clk);
        stall_cnt = 0;
        #2 rst_n = 1'b1;
        tick();
        q = '{mk(3'd5, 7'b0110011, 5'd7, 5'd8, 5'd9, 3'd3, 32'd0, 1'b1)};
        run_session(q);

        for (int s = 0; s < 80; s++) begin
            int n;
            n = 1 + int'($urandom % 10);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(rand_ent());
            q[n - 1].last = 1'b1;
            run_session(q);
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
